// File: rtl/butterfly_sequencer.sv
// -----------------------------------------------------------------------------
// butterfly_sequencer
//
// Sequencer for a radix-2 FFT butterfly, y = a + W*b and z = a - W*b.
// Operands are entered one byte at a time from the slide switches, and each
// byte is stepped in by the push switch. One shared 8x8 signed multiplier is
// driven through the four partial products. The four results are then shown
// one after another. W is kept across butterflies until reset.
//
// Ports
//   fastclk : 50 MHz board clock; all state changes on the rising edge
//   nReset  : asynchronous, active-low reset
//   step    : raw push-switch level, asynchronous to fastclk
//   din     : operand byte, two's complement
//             (W components are Q1.7; a and b components are integers)
//   led     : integer part (floor) of the selected result, saturated to 8 bits
//   result  : selected result at full precision, Q11.7 signed
//   busy    : high while the multiply sequence runs
//   done    : one-cycle pulse in the cycle the y/z registers load
//   phase   : current state code, for debug
// -----------------------------------------------------------------------------
module butterfly_sequencer #(
  parameter int RES_W = 18
) (
  input  logic             fastclk,
  input  logic             nReset,
  input  logic             step,
  input  logic [7:0]       din,
  output logic [7:0]       led,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [3:0]       phase
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;

  typedef enum logic [3:0] {
    S_WRE = 4'd0,
    S_WIM = 4'd1,
    S_BRE = 4'd2,
    S_BIM = 4'd3,
    S_ARE = 4'd4,
    S_AIM = 4'd5,
    S_MUL = 4'd6,
    S_YRE = 4'd7,
    S_YIM = 4'd8,
    S_ZRE = 4'd9,
    S_ZIM = 4'd10
  } state_t;

  state_t state, state_nx;

  logic step_p1, step_p2, step_p3;
  logic pulse;

  logic signed [COEF_W-1:0] wre, wim;
  logic signed [DATA_W-1:0] bre, bim, are, aim;
  logic        [2:0]        m;

  logic signed [COEF_W-1:0] mul_x;
  logic signed [DATA_W-1:0] mul_y;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [RES_W-1:0]  yre, yim, zre, zim;
  logic signed [RES_W-1:0]  res_sel;

  // Widen an accumulator value to the result width.
  function automatic logic signed [RES_W-1:0] ext_acc(input logic signed [ACC_W-1:0] v);
    return {{(RES_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  // Place an integer operand on the Q.7 grid of the result.
  function automatic logic signed [RES_W-1:0] ext_a(input logic signed [DATA_W-1:0] v);
    return {{(RES_W-DATA_W-7){v[DATA_W-1]}}, v, 7'b0};
  endfunction

  // Floor of the integer part, clamped to the signed 8-bit range.
  function automatic logic [7:0] sat_led(input logic signed [RES_W-1:0] v);
    if ((v[RES_W-1:14] == '0) || (v[RES_W-1:14] == '1)) return v[14:7];
    else if (v[RES_W-1])                                return 8'h80;
    else                                                return 8'h7F;
  endfunction

  // ---- stage p1..p3: step synchronizer and registered rising-edge pulse ----
  always_ff @(posedge fastclk or negedge nReset) begin
    if (!nReset) begin
      step_p1 <= 1'b0;
      step_p2 <= 1'b0;
      step_p3 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      step_p1 <= step;
      step_p2 <= step_p1;
      step_p3 <= step_p2;
      pulse   <= step_p2 & ~step_p3;
    end
  end

  // ---- control: state register and next-state logic ----
  always_ff @(posedge fastclk or negedge nReset) begin
    if (!nReset) state <= S_WRE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WRE: if (pulse) state_nx = S_WIM;
      S_WIM: if (pulse) state_nx = S_BRE;
      S_BRE: if (pulse) state_nx = S_BIM;
      S_BIM: if (pulse) state_nx = S_ARE;
      S_ARE: if (pulse) state_nx = S_AIM;
      S_AIM: if (pulse) state_nx = S_MUL;
      // Pulses arriving here are dropped, not queued.
      S_MUL: if (m == 3'd4) state_nx = S_YRE;
      S_YRE: if (pulse) state_nx = S_YIM;
      S_YIM: if (pulse) state_nx = S_ZRE;
      S_ZRE: if (pulse) state_nx = S_ZIM;
      // W is kept; the next butterfly reloads only b and a.
      S_ZIM: if (pulse) state_nx = S_BRE;
      default:          state_nx = S_WRE;
    endcase
  end

  // ---- shared multiplier: the operand pair is selected by the step counter ----
  always_comb begin
    mul_x = wre;
    mul_y = bre;
    case (m)
      3'd1: begin mul_x = wim; mul_y = bim; end
      3'd2: begin mul_x = wre; mul_y = bim; end
      3'd3: begin mul_x = wim; mul_y = bre; end
      default: begin mul_x = wre; mul_y = bre; end
    endcase
  end

  assign prod     = mul_x * mul_y;
  assign prod_ext = {prod[PROD_W-1], prod};

  // ---- operand loads, multiply-accumulate, and y/z results ----
  always_ff @(posedge fastclk or negedge nReset) begin
    if (!nReset) begin
      wre    <= '0;
      wim    <= '0;
      bre    <= '0;
      bim    <= '0;
      are    <= '0;
      aim    <= '0;
      m      <= '0;
      acc_re <= '0;
      acc_im <= '0;
      yre    <= '0;
      yim    <= '0;
      zre    <= '0;
      zim    <= '0;
    end else begin
      if (pulse) begin
        case (state)
          S_WRE:   wre <= din;
          S_WIM:   wim <= din;
          S_BRE:   bre <= din;
          S_BIM:   bim <= din;
          S_ARE:   are <= din;
          S_AIM:   aim <= din;
          default: ;
        endcase
      end
      if (state == S_MUL) begin
        m <= m + 3'd1;
        case (m)
          3'd0: acc_re <= prod_ext;
          3'd1: acc_re <= acc_re - prod_ext;
          3'd2: acc_im <= prod_ext;
          3'd3: acc_im <= acc_im + prod_ext;
          3'd4: begin
            yre <= ext_a(are) + ext_acc(acc_re);
            yim <= ext_a(aim) + ext_acc(acc_im);
            zre <= ext_a(are) - ext_acc(acc_re);
            zim <= ext_a(aim) - ext_acc(acc_im);
          end
          default: ;
        endcase
      end else begin
        m <= '0;
      end
    end
  end

  // ---- display select and outputs ----
  always_comb begin
    res_sel = '0;
    case (state)
      S_YRE:   res_sel = yre;
      S_YIM:   res_sel = yim;
      S_ZRE:   res_sel = zre;
      S_ZIM:   res_sel = zim;
      default: res_sel = '0;
    endcase
  end

  assign result = res_sel;
  assign led    = sat_led(res_sel);
  assign busy   = (state == S_MUL);
  assign done   = (state == S_MUL) && (m == 3'd4);
  assign phase  = state;

endmodule
